// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings and default sizes for the unified SRAM arbiter
package mem_arbiter_pkg;
  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 32;
  localparam int MEM_LAT_DEF = 1;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_e;
  typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_e;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one fixed-latency SRAM between fetch and data ports
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ready,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_ma
);
  state_e state_q;
  owner_e owner_q, last_q, own_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, if_rdata_q, dm_rdata_q;
  logic [DATA_W/8-1:0] mem_we_q;
  logic [3:0] cnt_q;
  logic wr_q, mem_en_q, if_ready_q, dm_ready_q, to_resp;
  always_comb begin
    own_d   = (dm_req && (!if_req || last_q == OWN_IF)) ? OWN_DM : OWN_IF;
    addr_d  = (own_d == OWN_DM ? dm_addr : if_addr) & {{(ADDR_W-2){1'b1}}, 2'b00};
    to_resp = (state_q == ISSUE && MEM_LAT == 1) || (state_q == WAIT && cnt_q == 4'd1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      last_q     <= OWN_IF;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      cnt_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= '0;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      mem_en_q   <= 1'b0;
      mem_we_q   <= '0;
      if_ready_q <= to_resp && owner_q == OWN_IF;
      dm_ready_q <= to_resp && owner_q == OWN_DM;
      case (state_q)
        IDLE: if (if_req || dm_req) begin
          state_q  <= ISSUE;
          owner_q  <= own_d;
          addr_q   <= addr_d;
          wr_q     <= own_d == OWN_DM && dm_we;
          wdata_q  <= own_d == OWN_DM ? dm_wdata : '0;
          mem_en_q <= 1'b1;
          mem_we_q <= (own_d == OWN_DM && dm_we) ? dm_be : '0;
        end
        ISSUE: begin
          cnt_q   <= 4'(MEM_LAT - 1);
          state_q <= MEM_LAT > 1 ? WAIT : RESP;
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= RESP;
        end
        RESP: begin
          if (owner_q == OWN_IF) if_rdata_q <= mem_rdata;
          else if (!wr_q) dm_rdata_q <= mem_rdata;
          last_q  <= owner_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // read data is only valid from the SRAM during RESP, so bypass it while ready pulses
  assign if_rdata  = if_ready_q ? mem_rdata : if_rdata_q;
  assign dm_rdata  = (dm_ready_q && !wr_q) ? mem_rdata : dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign stall_ma  = !rst && ((if_req && !if_ready_q) || (dm_req && !dm_ready_q));
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified SRAM between the instruction-fetch port and the data-memory port of the pipelined CPU.
- Sits between cpu and memory inside Top.
- Sequences each access through a fixed-latency memory protocol and arbitrates between the two ports.
- Produces the memory-access stall (Stall_MA) consumed by the pipeline.

Parameters:
- ADDR_W, 16, byte-address width.
- DATA_W, 32, word width (byte strobes = DATA_W/8).
- MEM_LAT, 1, cycles from the mem_en cycle to the cycle rdata is valid; legal range 1..15.

Ports:
- clk  input  1  clock, all state changes on rising edge
- rst  input  1  synchronous active-high reset
- if_req  input  1  instruction fetch request (level, held until if_ready)
- if_addr  input  ADDR_W  fetch byte address
- if_rdata  output  DATA_W  fetched word
- if_ready  output  1  one-cycle completion pulse for fetch
- dm_req  input  1  data request (level, held until dm_ready)
- dm_we  input  1  1 = write, 0 = read
- dm_be  input  DATA_W/8  write byte enables
- dm_addr  input  ADDR_W  data byte address
- dm_wdata  input  DATA_W  write data
- dm_rdata  output  DATA_W  read data
- dm_ready  output  1  one-cycle completion pulse for data
- mem_en  output  1  memory access strobe, one cycle per access
- mem_we  output  DATA_W/8  byte write enables, 0 = read
- mem_addr  output  ADDR_W  word-aligned address, low 2 bits forced 0
- mem_wdata  output  DATA_W  write data to memory
- mem_rdata  input  DATA_W  memory read data
- stall_ma  output  1  memory-access stall to pipeline

Behaviour:
- Reset (sync, rst=1 at an edge):
  - State -> IDLE; last_grant -> IF.
  - All outputs 0, including rdata registers.
  - Any in-flight access is abandoned and its response ignored.
  - Reset mid-operation behaves identically.
- FSM states:
  - IDLE: evaluate requests. If any is pending, latch owner, address, we, be and wdata, then go to ISSUE.
  - ISSUE: mem_en=1 for exactly this cycle. mem_we = dm_be if the owner is DM with dm_we=1, else 0. mem_addr and mem_wdata come from the latched values. Load the latency counter with MEM_LAT-1. Go to WAIT if MEM_LAT>1, else RESP.
  - WAIT: decrement counter; go to RESP when it reaches 0.
  - RESP: sample mem_rdata into the owner's rdata register (reads only; writes leave it unchanged). Pulse the owner's ready for this cycle. Update last_grant = owner. Go to IDLE.
- Latency:
  - Request first seen in IDLE at cycle t: mem_en at t+1, ready at t+1+MEM_LAT.
  - Next grant is possible at t+2+MEM_LAT.
  - MEM_LAT=1 gives 3 cycles per access.
- Arbitration in IDLE:
  - Single requester: granted.
  - Both requesting: grant the port that is not last_grant (round-robin). After reset the first conflict goes to DM.
  - Requests that deassert before being granted are dropped silently. A deasserting request after grant is a protocol violation: the access still completes and ready still pulses.
- if_rdata and dm_rdata are registered and hold their value until the next read completion on that port.
- stall_ma = (if_req & ~if_ready) | (dm_req & ~dm_ready), combinational. It is 0 during reset.
- A write with dm_be=0 is issued with mem_we=0. It completes normally with dm_ready and does not update dm_rdata.
- Address bits [1:0] are ignored.
- Only one access is ever outstanding; there is no request queueing inside the block.

Decomposition:
- Shared package/header holds:
  - State encodings IDLE=0, ISSUE=1, WAIT=2, RESP=3.
  - Owner encoding OWN_IF=0, OWN_DM=1.
  - Default ADDR_W, DATA_W and MEM_LAT constants, shared with the memory model and cpu.
- No sub-module is needed; the latency counter is inline.
- The existing memory model becomes the slave of the mem_* port.

Test Plan:
- IF-only read, MEM_LAT=1: mem[0x0000..3]=0x00500093; if_req=1, if_addr=0x0000 at t -> mem_en at t+1, if_ready=1 and if_rdata=0x00500093 at t+2; stall_ma=1 during t and t+1, 0 at t+2.
- DM write then read: dm_we=1, be=4'b0011, addr=0x8002, wdata=0xAABBCCDD -> mem_addr=0x8000, mem_we=4'b0011. A following read of 0x8000 returns the lower two bytes from 0xAABBCCDD with the upper bytes unchanged.
- Simultaneous if_req and dm_req right after reset:
  - DM is granted first and dm_ready occurs at cycle 3.
  - IF's ISSUE follows one cycle later, with if_ready at cycle 6.
  - On the next conflict, IF wins (round-robin).
- MEM_LAT=4: a single DM read shows ready exactly 5 cycles after mem_en's predecessor IDLE cycle, and mem_en is high for exactly 1 cycle.
- rst asserted during WAIT:
  - The next cycle is IDLE with all outputs 0.
  - No ready pulse is produced and the stale mem_rdata is not captured.
  - A new request after reset completes normally.
- Continuous if_req for 20 cycles with periodic dm_req: every access produces exactly one ready, and neither port waits more than one foreign access.
